fifo_arbiter: RTL

- Shares the write port of the 16-bit `fifo` between two producers (A, B) and sequences reads to a single consumer.
- Write side: a 3-state ownership FSM with a round-robin pointer and a per-owner burst limit drives `push`/`data_in`, and honours `fifo_full`.
- Read side: converts a consumer read request into a `pop` pulse plus a registered, one-cycle-later data-valid.
- Sits directly between the producers/consumer and the `fifo` instance.

---
 rtl/fifo_arbiter.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fifo_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_arbiter
//
// Sits between two producers (A, B), one consumer and a single `fifo`
// instance. The write side shares the fifo push port between the producers
// using a three-state ownership FSM. The read side turns a consumer request
// into a pop pulse and returns the popped word one cycle later.
//
// Write side
//   IDLE  : nobody owns the port. The next owner is picked from the valid
//           producers, and the round-robin pointer breaks ties.
//   OWN_A : A owns the port. B is held off.
//   OWN_B : B owns the port. A is held off.
//   While it owns the port, a producer may push one word per cycle unless
//   the fifo is full. On a full stall the owner keeps the port and the
//   burst count holds its value.
//   When a burst reaches BURST_MAX and the other side is waiting, the port
//   is handed over with no idle cycle in between.
//
// Read side
//   pop      = rd_req & ~fifo_empty & ~reset   (same cycle)
//   rd_valid = registered pop                  (one-cycle pulse)
//   rd_data  = head word captured in the pop cycle. It holds otherwise.
//
// Parameters
//   DATA_WIDTH : word width. It must match the fifo.
//   BURST_MAX  : words accepted per ownership while the other side waits
//                (1..15).
//
// Ports
//   clk, reset                 : rising-edge clock, synchronous active-high reset
//   a_valid/a_data/a_ready     : producer A handshake
//   b_valid/b_data/b_ready     : producer B handshake
//   push, data_in              : fifo write port (push only on accepted words)
//   fifo_full, fifo_empty      : fifo status, used in the same cycle
//   rd_req                     : consumer asks for one word
//   pop                        : fifo read strobe
//   fifo_data_out              : fifo head word (combinational)
//   rd_valid, rd_data          : popped word, returned one cycle after pop
//
// Configuration macro
//   FIFO_ARB_FIXED_PRIO_EN : when defined, A has fixed priority.
//     - A wins in IDLE.
//     - OWN_A ignores the burst limit.
//     - OWN_B gives up the port after any accepted word while A is valid.
//     - The round-robin pointer is not used.
//   When undefined (the default build), arbitration is round-robin with a
//   burst limit.
// -----------------------------------------------------------------------------
module fifo_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // producer A
  input  logic                  a_valid,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  // producer B
  input  logic                  b_valid,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  // fifo write port
  output logic                  push,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  // consumer / fifo read port
  input  logic                  rd_req,
  output logic                  pop,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_e;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_e;

  localparam logic [3:0] BURST_LIMIT = 4'(BURST_MAX);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                state_q,     state_d;
  side_e                 rr_next_q,   rr_next_d;
  logic [3:0]            burst_cnt_q, burst_cnt_d;
  logic                  rd_valid_q,  rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q,   rd_data_d;

  // Owner view of the handshake. The owner and "other" sides are decoded
  // from the state, so one path serves both OWN_A and OWN_B.
  logic own_is_a;
  logic own_valid;
  logic other_valid;
  logic accept;
  logic leave;

  // ---------------------------------------------------------------------------
  // Write side: ownership FSM, next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin : write_side
    // NOTE: every signal this block drives gets a default value before any
    // branch. If a path skipped an assignment, synthesis would infer a latch.
    state_d     = state_q;
    rr_next_d   = rr_next_q;
    burst_cnt_d = burst_cnt_q;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    push        = 1'b0;
    data_in     = '0;
    accept      = 1'b0;
    leave       = 1'b0;

    own_is_a    = (state_q == ST_OWN_A);
    own_valid   = own_is_a ? a_valid : b_valid;
    other_valid = own_is_a ? b_valid : a_valid;

    case (state_q)
      ST_IDLE: begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
        if (a_valid) begin
          state_d = ST_OWN_A;
        end else if (b_valid) begin
          state_d = ST_OWN_B;
        end
`else
        if (a_valid && b_valid) begin
          state_d = (rr_next_q == SIDE_A) ? ST_OWN_A : ST_OWN_B;
        end else if (a_valid) begin
          state_d = ST_OWN_A;
        end else if (b_valid) begin
          state_d = ST_OWN_B;
        end
`endif
      end

      ST_OWN_A, ST_OWN_B: begin
        // Ready depends only on fifo space. It is independent of valid.
        a_ready = own_is_a  & ~fifo_full;
        b_ready = ~own_is_a & ~fifo_full;
        accept  = own_valid & ~fifo_full;
        push    = accept;
        data_in = own_is_a ? a_data : b_data;

`ifdef FIFO_ARB_FIXED_PRIO_EN
        // A keeps the port for as long as it is valid. B gives the port up
        // as soon as A asks, but only after B has moved a word, so B is
        // never granted and then refused.
        if (!own_valid) begin
          leave = 1'b1;
        end else if (!own_is_a && accept && other_valid) begin
          leave = 1'b1;
        end

        if (leave) begin
          state_d = other_valid ? (own_is_a ? ST_OWN_B : ST_OWN_A) : ST_IDLE;
        end
`else
        begin : rr_yield
          logic [3:0] cnt_inc;
          // This count includes the word accepted this cycle. The limit
          // therefore takes effect on the accept that reaches it, and the
          // handoff leaves no bubble. A stalled cycle adds zero, so the
          // count holds.
          cnt_inc = burst_cnt_q + 4'(accept);

          if (!own_valid) begin
            leave = 1'b1;
          end else if (cnt_inc == BURST_LIMIT) begin
            if (other_valid) begin
              leave = 1'b1;
            end else begin
              // Nobody is waiting. Keep ownership and start a fresh burst.
              burst_cnt_d = '0;
            end
          end else begin
            burst_cnt_d = cnt_inc;
          end
        end

        if (leave) begin
          state_d     = other_valid ? (own_is_a ? ST_OWN_B : ST_OWN_A) : ST_IDLE;
          rr_next_d   = own_is_a ? SIDE_B : SIDE_A;
          burst_cnt_d = '0;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset gates the handshake in the same cycle, even in the middle of a
    // burst. A producer must never see a word accepted that the fifo will
    // not keep.
    if (reset) begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      push    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  assign pop = rd_req & ~fifo_empty & ~reset;

  always_comb begin : read_side
    rd_valid_d = pop;
    // The fifo head is combinational. Capture it in the pop cycle, before
    // the fifo moves to the next word.
    rd_data_d  = pop ? fifo_data_out : rd_data_q;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments. Every flop then
    // samples values from before the edge, whatever order the code is in.
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_next_q   <= SIDE_A;
      burst_cnt_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_next_q   <= rr_next_d;
      burst_cnt_q <= burst_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  // ---------------------------------------------------------------------------
  // Interface invariants
  // ---------------------------------------------------------------------------
  a_push_not_full : assert property (@(posedge clk) disable iff (reset)
    push |-> !fifo_full);

  a_pop_not_empty : assert property (@(posedge clk) disable iff (reset)
    pop |-> !fifo_empty);

  a_single_ready : assert property (@(posedge clk) disable iff (reset)
    !(a_ready && b_ready));

  a_push_is_handshake : assert property (@(posedge clk) disable iff (reset)
    push |-> ((a_valid && a_ready) || (b_valid && b_ready)));

endmodule
